// File: rtl/keypad_scan_if.sv
// Signal bundle between the 4x4 keypad matrix scanner and its consumer.
// master = scanner side, slave = keypad/consumer side.
interface keypad_scan_if;
  logic [3:0] row_out;
  logic [3:0] col_in;
  logic       btn_valid;
  logic [7:0] btn_char;
  logic       key_held;

  modport master (
    output row_out,
    output btn_valid,
    output btn_char,
    output key_held,
    input  col_in
  );

  modport slave (
    input  row_out,
    input  btn_valid,
    input  btn_char,
    input  key_held,
    output col_in
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 membrane keypad scanner with frame-based debounce.
// Emits one btn_valid pulse with an ASCII btn_char per accepted key press.
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.master kp
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {StIdle, StPress, StHeld, StRel} state_e;

  function automatic logic [1:0] low_col(input logic [3:0] low);
    logic [1:0] c;
    if (low[0])      c = 2'd0;
    else if (low[1]) c = 2'd1;
    else if (low[2]) c = 2'd2;
    else             c = 2'd3;
    return c;
  endfunction

  // Key index is {row, col}.
  function automatic logic [7:0] key_char(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:    c = 8'h31;
      4'd1:    c = 8'h32;
      4'd2:    c = 8'h33;
      4'd3:    c = 8'h2B;
      4'd4:    c = 8'h34;
      4'd5:    c = 8'h35;
      4'd6:    c = 8'h36;
      4'd7:    c = 8'h2D;
      4'd8:    c = 8'h37;
      4'd9:    c = 8'h38;
      4'd10:   c = 8'h39;
      4'd11:   c = 8'h2A;
      4'd12:   c = 8'h43;
      4'd13:   c = 8'h30;
      4'd14:   c = 8'h3D;
      default: c = 8'h08;
    endcase
    return c;
  endfunction

  logic [3:0]      sync1_q, sync2_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_q, row_d;
  logic            acc_any_q, acc_any_d;
  logic            acc_multi_q, acc_multi_d;
  logic [3:0]      acc_code_q, acc_code_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic [7:0]      char_q, char_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;

  logic       sample, frame_end;
  logic [3:0] row_low;
  logic       row_any;
  logic       frm_any, frm_multi, frm_none, frm_single;
  logic [3:0] frm_code;

  // Sample at the last dwell cycle so the driven row has fully settled.
  assign sample    = (div_q == DivW'(SCAN_DIV - 1));
  assign frame_end = sample && (row_q == 2'd3);

  // Running frame classification including the row being sampled now.
  assign row_low    = ~sync2_q;
  assign row_any    = |row_low;
  assign frm_any    = acc_any_q | row_any;
  assign frm_multi  = acc_multi_q | (row_any & (acc_any_q | !$onehot(row_low)));
  assign frm_code   = row_any ? {row_q, low_col(row_low)} : acc_code_q;
  assign frm_none   = !frm_any;
  assign frm_single = frm_any && !frm_multi;

  always_comb begin
    div_d       = div_q + DivW'(1);
    row_d       = row_q;
    acc_any_d   = acc_any_q;
    acc_multi_d = acc_multi_q;
    acc_code_d  = acc_code_q;
    if (sample) begin
      div_d = '0;
      row_d = row_q + 2'd1;
      if (frame_end) begin
        acc_any_d   = 1'b0;
        acc_multi_d = 1'b0;
        acc_code_d  = '0;
      end else begin
        acc_any_d   = frm_any;
        acc_multi_d = frm_multi;
        acc_code_d  = frm_code;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    char_d  = char_q;
    held_d  = held_q;
    valid_d = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        StIdle, StPress: begin
          if (frm_single) begin
            cand_d = frm_code;
            cnt_d  = (state_q == StPress && frm_code == cand_q) ? cnt_q + CntW'(1) : CntW'(1);
            if (cnt_d == CntW'(DEBOUNCE_SCANS)) begin
              char_d  = key_char(frm_code);
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = StHeld;
            end else begin
              state_d = StPress;
            end
          end else begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
        StHeld, StRel: begin
          if (frm_none) begin
            cnt_d = (state_q == StRel) ? cnt_q + CntW'(1) : CntW'(1);
            if (cnt_d == CntW'(DEBOUNCE_SCANS)) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              state_d = StRel;
            end
          end else begin
            // Any activity while held or releasing pins the key as held; no repeat.
            cnt_d   = '0;
            state_d = StHeld;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      div_q       <= '0;
      row_q       <= '0;
      acc_any_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_code_q  <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= '0;
      char_q      <= '0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      sync1_q     <= kp.col_in;
      sync2_q     <= sync1_q;
      div_q       <= div_d;
      row_q       <= row_d;
      acc_any_q   <= acc_any_d;
      acc_multi_q <= acc_multi_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      char_q      <= char_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
    end
  end

  assign kp.row_out   = ~(4'b0001 << row_q);
  assign kp.btn_valid = valid_q;
  assign kp.btn_char  = char_q;
  assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a physical keypad model drives the columns and a
// frame-level debounce model predicts every output cycle by cycle.
module tb_keypad_scan;

  localparam int Deb = 3;

  logic        clk;
  logic        rst_n;
  logic [15:0] pressed;
  logic [3:0]  col_drive;
  logic [31:0] cyc;

  int n_checks;
  int n_fail;
  int pulses;
  int last_pulse;

  // Reference model state: held flag, run length, candidate key, last accepted char.
  int         m_run;
  int         m_cand;
  logic       m_held;
  logic [7:0] m_char;

  logic [7:0] keymap [16];

  keypad_scan_if kp ();

  keypad_scan #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(Deb)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kp   (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  // A pressed key shorts its column to its row while that row is driven low.
  always_comb begin
    col_drive = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !kp.row_out[r]) col_drive[c] = 1'b0;
      end
    end
  end
  assign kp.col_in = col_drive;

  function automatic logic [15:0] key(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  task automatic model_reset();
    m_run  = 0;
    m_cand = 0;
    m_held = 1'b0;
    m_char = 8'h00;
  endtask

  // One full 16-cycle frame with a fixed key set; checks every cycle against the model.
  task automatic run_frame(input logic [15:0] keys);
    logic       old_held;
    logic [7:0] old_char;
    logic       pulse;
    logic [3:0] exp_row;
    int         n;
    int         idx;
    pressed  = keys;
    old_held = m_held;
    old_char = m_char;
    pulse    = 1'b0;
    n        = $countones(keys);
    idx      = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) idx = i;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && idx == m_cand) m_run++;
        else begin
          m_run  = 1;
          m_cand = idx;
        end
        if (m_run == Deb) begin
          pulse  = 1'b1;
          m_held = 1'b1;
          m_char = keymap[m_cand];
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (n == 0) begin
        m_run++;
        if (m_run == Deb) begin
          m_held = 1'b0;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      exp_row = ~(4'b0001 << cyc[3:2]);
      n_checks++;
      if (kp.row_out !== exp_row) begin
        n_fail++;
        $display("FAIL row_out cyc=%0d: got %b want %b", cyc, kp.row_out, exp_row);
      end
      n_checks++;
      if (kp.btn_valid !== ((i == 15) ? pulse : 1'b0)) begin
        n_fail++;
        $display("FAIL btn_valid cyc=%0d: got %b want %b", cyc, kp.btn_valid,
                 (i == 15) ? pulse : 1'b0);
      end
      n_checks++;
      if (kp.key_held !== ((i == 15) ? m_held : old_held)) begin
        n_fail++;
        $display("FAIL key_held cyc=%0d: got %b want %b", cyc, kp.key_held,
                 (i == 15) ? m_held : old_held);
      end
      n_checks++;
      if (kp.btn_char !== ((i == 15) ? m_char : old_char)) begin
        n_fail++;
        $display("FAIL btn_char cyc=%0d: got %h want %h", cyc, kp.btn_char,
                 (i == 15) ? m_char : old_char);
      end
      if (kp.btn_valid === 1'b1) begin
        pulses++;
        last_pulse = int'(cyc);
      end
    end
  endtask

  task automatic release_frames();
    for (int f = 0; f < Deb; f++) run_frame('0);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pressed = key(1, 2);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (kp.row_out !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_row_out: got %b want 1110", kp.row_out);
    end
    n_checks++;
    if (kp.btn_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_btn_valid: got %b want 0", kp.btn_valid);
    end
    n_checks++;
    if (kp.btn_char !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_btn_char: got %h want 00", kp.btn_char);
    end
    n_checks++;
    if (kp.key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_key_held: got %b want 0", kp.key_held);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_press_hold();
    pulses = 0;
    for (int f = 0; f < 5; f++) run_frame(key(1, 2));
    n_checks++;
    if (last_pulse != 48) begin
      n_fail++;
      $display("FAIL first_pulse_cycle: got %0d want 48", last_pulse);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL press6_pulse_count: got %0d want 1", pulses);
    end
    n_checks++;
    if (kp.btn_char !== 8'h36) begin
      n_fail++;
      $display("FAIL press6_char: got %h want 36", kp.btn_char);
    end
  endtask

  task automatic test_release_backspace();
    pulses = 0;
    release_frames();
    n_checks++;
    if (kp.key_held !== 1'b0 || pulses != 0) begin
      n_fail++;
      $display("FAIL release6: got held=%b pulses=%0d want held=0 pulses=0", kp.key_held, pulses);
    end
    for (int f = 0; f < 4; f++) run_frame(key(3, 3));
    n_checks++;
    if (kp.btn_char !== 8'h08 || pulses != 1) begin
      n_fail++;
      $display("FAIL backspace: got %h/%0d want 08/1", kp.btn_char, pulses);
    end
  endtask

  task automatic test_bounce();
    release_frames();
    pulses = 0;
    run_frame(key(0, 3));
    run_frame('0);
    for (int f = 0; f < 4; f++) run_frame(key(0, 3));
    n_checks++;
    if (kp.btn_char !== 8'h2B || pulses != 1) begin
      n_fail++;
      $display("FAIL bounce_plus: got %h/%0d want 2b/1", kp.btn_char, pulses);
    end
  endtask

  task automatic test_multi();
    release_frames();
    pulses = 0;
    for (int f = 0; f < 4; f++) run_frame(key(0, 0) | key(2, 1));
    n_checks++;
    if (kp.key_held !== 1'b0 || pulses != 0) begin
      n_fail++;
      $display("FAIL multi_idle: got held=%b pulses=%0d want 0/0", kp.key_held, pulses);
    end
    for (int f = 0; f < 3; f++) run_frame(key(0, 0));
    n_checks++;
    if (kp.btn_char !== 8'h31 || pulses != 1) begin
      n_fail++;
      $display("FAIL multi_then_one: got %h/%0d want 31/1", kp.btn_char, pulses);
    end
  endtask

  task automatic test_second_key();
    release_frames();
    pulses = 0;
    for (int f = 0; f < 3; f++) run_frame(key(1, 1));
    for (int f = 0; f < 3; f++) run_frame(key(1, 1) | key(2, 2));
    n_checks++;
    if (kp.btn_char !== 8'h35 || pulses != 1) begin
      n_fail++;
      $display("FAIL hold5_add9: got %h/%0d want 35/1", kp.btn_char, pulses);
    end
    release_frames();
    for (int f = 0; f < 3; f++) run_frame(key(2, 2));
    n_checks++;
    if (kp.btn_char !== 8'h39 || pulses != 2) begin
      n_fail++;
      $display("FAIL press9: got %h/%0d want 39/2", kp.btn_char, pulses);
    end
  endtask

  task automatic test_reset_mid();
    release_frames();
    for (int f = 0; f < 2; f++) run_frame(key(3, 0));
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (kp.row_out !== 4'b1110 || kp.btn_valid !== 1'b0 || kp.btn_char !== 8'h00 ||
        kp.key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got row=%b v=%b ch=%h h=%b want 1110/0/00/0",
               kp.row_out, kp.btn_valid, kp.btn_char, kp.key_held);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    pulses = 0;
    for (int f = 0; f < 4; f++) run_frame(key(3, 0));
    n_checks++;
    if (kp.btn_char !== 8'h43 || pulses != 1 || last_pulse != 48) begin
      n_fail++;
      $display("FAIL after_reset_C: got %h/%0d@%0d want 43/1@48", kp.btn_char, pulses,
               last_pulse);
    end
  endtask

  task automatic test_random();
    logic [15:0] keys;
    int          kidx;
    int          len;
    int          gap;
    for (int it = 0; it < 16; it++) begin
      kidx = int'($urandom_range(0, 15));
      len  = int'($urandom_range(1, 5));
      for (int f = 0; f < len; f++) begin
        keys = 16'(1) << kidx;
        if ($urandom_range(0, 5) == 0) keys = keys | (16'(1) << $urandom_range(0, 15));
        run_frame(keys);
      end
      gap = int'($urandom_range(0, 4));
      for (int f = 0; f < gap; f++) run_frame('0);
    end
  endtask

  initial begin
    keymap = '{8'h31, 8'h32, 8'h33, 8'h2B, 8'h34, 8'h35, 8'h36, 8'h2D,
               8'h37, 8'h38, 8'h39, 8'h2A, 8'h43, 8'h30, 8'h3D, 8'h08};
    n_checks   = 0;
    n_fail     = 0;
    pulses     = 0;
    last_pulse = -1;
    model_reset();
    test_reset();
    test_press_hold();
    test_release_backspace();
    test_bounce();
    test_multi();
    test_second_key();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
